lif_neuron_param: RTL



---
 rtl/lif_neuron_param.sv | 88 ++++++++
 1 files changed

// File: rtl/lif_neuron_param.sv
// Leaky integrate-and-fire neuron: saturating membrane, shift leak, runtime threshold, refractory hold.
// Latency: one cycle from sampled input to spike/membrane; no backpressure, en=0 freezes all state.
module lif_neuron_param #(
    parameter int IN_W        = 8,
    parameter int POT_W       = 12,
    parameter int LEAK_SHIFT  = 3,
    parameter int REFRACT_CYC = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_current,
    input  logic [POT_W-1:0] thresh,
    output logic             spike,
    output logic [POT_W-1:0] membrane,
    output logic             refractory,
    output logic [CNT_W-1:0] spike_cnt
);
    typedef enum logic {INTEG, REFRACT} state_t;

    localparam int RC_W = (REFRACT_CYC > 1) ? $clog2(REFRACT_CYC) : 1;
    localparam logic [RC_W-1:0] REFR_LOAD = (REFRACT_CYC > 0) ? RC_W'(REFRACT_CYC - 1) : '0;

    state_t          state;
    logic [RC_W-1:0] refr_cnt;

    logic [POT_W:0]   leak;
    logic [POT_W:0]   add;
    logic [POT_W:0]   sum;
    logic [POT_W-1:0] v_new;
    logic             fire;

    // One extra bit of headroom so an overflowing sum can be clamped instead of wrapping.
    always_comb begin
        leak  = (LEAK_SHIFT == 0) ? '0 : ({1'b0, membrane} >> LEAK_SHIFT);
        add   = in_valid ? {{(POT_W + 1 - IN_W){1'b0}}, in_current} : '0;
        sum   = {1'b0, membrane} - leak + add;
        v_new = sum[POT_W] ? '1 : sum[POT_W-1:0];
        fire  = (v_new >= thresh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INTEG;
            refr_cnt   <= '0;
            spike      <= 1'b0;
            membrane   <= '0;
            refractory <= 1'b0;
            spike_cnt  <= '0;
        end else if (!en) begin
            spike <= 1'b0;
        end else begin
            case (state)
                INTEG: begin
                    if (fire) begin
                        spike     <= 1'b1;
                        membrane  <= '0;
                        spike_cnt <= spike_cnt + 1'b1;
                        if (REFRACT_CYC > 0) begin
                            state      <= REFRACT;
                            refractory <= 1'b1;
                            refr_cnt   <= REFR_LOAD;
                        end
                    end else begin
                        spike    <= 1'b0;
                        membrane <= v_new;
                    end
                end
                REFRACT: begin
                    spike    <= 1'b0;
                    membrane <= '0;
                    if (refr_cnt == '0) begin
                        state      <= INTEG;
                        refractory <= 1'b0;
                    end else begin
                        refr_cnt <= refr_cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= INTEG;
                    refractory <= 1'b0;
                end
            endcase
        end
    end
endmodule
